// File: rtl/datapath_ctrl.sv
// Instruction-driven sequencer for the 16-bit datapath: latches an instruction,
// decodes it and steps the regfile/A/B/C/status strobes through a Moore FSM.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_WAIT   | idle, w=1; IR accepts load, s starts execution
//  S_DECODE | classify IR; undefined opcode pulses bad_op and returns
//  S_GET_A  | read Rn into A
//  S_GET_B  | read Rm into B
//  S_EXEC   | shift/ALU into C, or status update for CMP
//  S_WR_REG | write C to Rd
//  S_WR_IMM | write sign-extended imm8 to Rn
module datapath_ctrl #(
    parameter logic [15:0] RESET_IR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic        bad_op,
    output logic [15:0] datapath_in,
    output logic        vsel,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [2:0]  readnum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [1:0]  shift,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_WR_IMM
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    logic [2:0] w_opc, w_rn, w_rd, w_rm;
    logic [1:0] w_op, w_sh;
    logic       w_is_mov_imm, w_is_mov_reg, w_is_alu, w_is_cmp, w_is_mvn, w_undef;

    assign w_opc = r_ir[15:13];
    assign w_op  = r_ir[12:11];
    assign w_rn  = r_ir[10:8];
    assign w_rd  = r_ir[7:5];
    assign w_sh  = r_ir[4:3];
    assign w_rm  = r_ir[2:0];

    assign w_is_mov_imm = (w_opc == 3'b110) && (w_op == 2'b10);
    assign w_is_mov_reg = (w_opc == 3'b110) && (w_op == 2'b00);
    assign w_is_alu     = (w_opc == 3'b101);
    assign w_is_cmp     = w_is_alu && (w_op == 2'b01);
    assign w_is_mvn     = w_is_alu && (w_op == 2'b11);
    assign w_undef      = !(w_is_mov_imm || w_is_mov_reg || w_is_alu);

    assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
    assign bsel        = 1'b0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The IR is frozen outside WAIT so a busy instruction cannot be corrupted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= RESET_IR;
        end else if ((r_state == S_WAIT) && load) begin
            r_ir <= in;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w        = 1'b0;
        bad_op   = 1'b0;
        vsel     = 1'b0;
        writenum = 3'd0;
        write    = 1'b0;
        readnum  = 3'd0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        shift    = 2'b00;
        asel     = 1'b0;
        ALUop    = 2'b00;
        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_mov_imm)                   w_next_state = S_WR_IMM;
                else if (w_is_mov_reg || w_is_mvn)  w_next_state = S_GET_B;
                else if (w_is_alu)                  w_next_state = S_GET_A;
                else                                w_next_state = S_WAIT;
                bad_op = w_undef;
            end
            S_GET_A: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                shift        = w_sh;
                ALUop        = w_is_alu ? w_op : 2'b00;
                asel         = w_is_mov_reg || w_is_mvn;
                loadc        = !w_is_cmp;
                loads        = w_is_cmp;
                w_next_state = w_is_cmp ? S_WAIT : S_WR_REG;
            end
            S_WR_REG: begin
                vsel         = 1'b0;
                writenum     = w_rd;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WR_IMM: begin
                vsel         = 1'b1;
                writenum     = w_rn;
                write        = 1'b1;
                w_next_state = S_WAIT;
            end
            default: w_next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural datapath driven by the DUT strobes is
// compared against an instruction-level model of the ISA.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in = 16'h0;
    logic        load = 1'b0;
    logic        s = 1'b0;
    logic        w, bad_op, vsel, write, loada, loadb, loadc, loads, asel, bsel;
    logic [15:0] datapath_in;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, ALUop;

    int n_checks = 0;
    int n_errors = 0;

    datapath_ctrl dut (
        .clk(clk), .reset_n(reset_n), .in(in), .load(load), .s(s),
        .w(w), .bad_op(bad_op), .datapath_in(datapath_in), .vsel(vsel),
        .writenum(writenum), .write(write), .readnum(readnum),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .shift(shift), .asel(asel), .bsel(bsel), .ALUop(ALUop)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] sh);
        case (sh)
            2'b01:   return {x[14:0], 1'b0};
            2'b10:   return {1'b0, x[15:1]};
            2'b11:   return {x[15], x[15:1]};
            default: return x;
        endcase
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    // Behavioural datapath that obeys whatever strobes the controller issues.
    logic [15:0] dp_r [8];
    logic [15:0] dp_a, dp_b, dp_c, dp_alu, dp_ain, dp_bin;
    logic        dp_z;

    always_comb begin
        dp_ain = asel ? 16'h0 : dp_a;
        dp_bin = shf(dp_b, shift);
        case (ALUop)
            2'b00:   dp_alu = dp_ain + dp_bin;
            2'b01:   dp_alu = dp_ain - dp_bin;
            2'b10:   dp_alu = dp_ain & dp_bin;
            default: dp_alu = ~dp_bin;
        endcase
    end

    always @(posedge clk) begin
        if (write) dp_r[writenum] <= vsel ? datapath_in : dp_c;
        if (loada) dp_a <= dp_r[readnum];
        if (loadb) dp_b <= dp_r[readnum];
        if (loadc) dp_c <= dp_alu;
        if (loads) dp_z <= (dp_alu == 16'h0);
    end

    int n_wr = 0, n_ld = 0, n_bad = 0, n_str = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (write)  n_wr++;
            if (loads)  n_ld++;
            if (bad_op) n_bad++;
            if (write || loada || loadb || loadc || loads) n_str++;
        end
    end

    logic [15:0] m_r [8];
    logic        m_z;
    bit          regs_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_instr(input logic [15:0] word, input bit interfere);
        logic [2:0]  opc, rn, rd, rm;
        logic [1:0]  op, sh;
        logic [15:0] bv, diff;
        int lat, wr, ld, bad, str, cyc, b_wr, b_ld, b_bad, b_str;
        bit imm, cmp;
        opc = word[15:13]; op = word[12:11]; rn = word[10:8];
        rd = word[7:5]; sh = word[4:3]; rm = word[2:0];
        bv = shf(m_r[rm], sh);
        imm = 0; cmp = 0; wr = 1; ld = 0; bad = 0;
        if (opc == 3'b110 && op == 2'b10) begin
            m_r[rn] = sext8(word[7:0]); lat = 3; str = 1; imm = 1;
        end else if (opc == 3'b110 && op == 2'b00) begin
            m_r[rd] = bv; lat = 5; str = 3;
        end else if (opc == 3'b101) begin
            case (op)
                2'b00: begin m_r[rd] = m_r[rn] + bv; lat = 6; str = 4; end
                2'b01: begin
                    diff = m_r[rn] - bv; m_z = (diff == 16'h0);
                    lat = 5; str = 3; wr = 0; ld = 1; cmp = 1;
                end
                2'b10: begin m_r[rd] = m_r[rn] & bv; lat = 6; str = 4; end
                default: begin m_r[rd] = ~bv; lat = 5; str = 3; end
            endcase
        end else begin
            lat = 2; str = 0; wr = 0; bad = 1;
        end

        @(negedge clk);
        chk("ready", w, 1);
        b_wr = n_wr; b_ld = n_ld; b_bad = n_bad; b_str = n_str;
        in = word; load = 1; s = 1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        load = 0; s = 0;
        chk("ir_load", datapath_in, sext8(word[7:0]));
        if (bad) chk("bad_op_decode", bad_op, 1);
        while (!w && cyc < 20) begin
            if (interfere && cyc == 3) begin in = 16'hD0FF; load = 1; s = 1; end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            load = 0; s = 0;
            if (imm && cyc == 2) begin
                chk("imm_vsel", vsel, 1);
                chk("imm_writenum", writenum, rn);
                chk("imm_write", write, 1);
                chk("imm_dpin", datapath_in, sext8(word[7:0]));
            end
        end
        chk("latency", cyc, lat);
        chk("write_cycles", n_wr - b_wr, wr);
        chk("loads_cycles", n_ld - b_ld, ld);
        chk("bad_op_cycles", n_bad - b_bad, bad);
        chk("strobe_cycles", n_str - b_str, str);
        chk("ir_hold", datapath_in, sext8(word[7:0]));
        if (cmp) chk("z_flag", dp_z, m_z);
        if (regs_valid)
            for (int i = 0; i < 8; i++) chk($sformatf("reg%0d", i), dp_r[i], m_r[i]);
    endtask

    function automatic logic [15:0] rand_instr();
        int k;
        logic [15:0] x;
        k = $urandom_range(0, 6);
        x = 16'($urandom);
        case (k)
            0: x[15:11] = 5'b11010;
            1: x[15:11] = 5'b11000;
            2, 3, 4, 5: x[15:11] = {3'b101, 2'(k - 2)};
            default: ;
        endcase
        return x;
    endfunction

    initial begin
        #2;
        chk("rst_w", w, 1);
        chk("rst_write", write, 0);
        chk("rst_dpin", datapath_in, 16'h0000);
        chk("rst_bad_op", bad_op, 0);
        @(negedge clk);
        reset_n = 1;

        for (int i = 0; i < 8; i++) run_instr({5'b11010, 3'(i), 8'($urandom)}, 0);
        regs_valid = 1;

        run_instr(16'hD007, 0);
        run_instr(16'hD102, 0);
        run_instr(16'hA148, 0);
        chk("add_r2", dp_r[2], 16'd16);
        chk("add_c", dp_c, 16'd16);

        run_instr(16'hA900, 0);
        chk("cmp_z0", dp_z, 0);
        run_instr(16'hD002, 0);
        run_instr(16'hA900, 0);
        chk("cmp_z1", dp_z, 1);

        run_instr(16'hD3FF, 0);
        chk("movneg_r3", dp_r[3], 16'hFFFF);
        run_instr(16'hE000, 0);
        run_instr(16'hA148, 1);
        chk("busy_r0", dp_r[0] != 16'hFFFF, 1);

        for (int i = 0; i < 60; i++) run_instr(rand_instr(), 0);

        // Asynchronous reset in the middle of an ADD.
        @(negedge clk);
        in = 16'hA148; load = 1; s = 1;
        @(posedge clk);
        @(negedge clk);
        load = 0; s = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exec_loadc", loadc, 1);
        reset_n = 0;
        #1;
        chk("async_w", w, 1);
        chk("async_write", write, 0);
        chk("async_loadc", loadc, 0);
        chk("async_dpin", datapath_in, 16'h0000);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk("post_rst_ir", datapath_in, 16'h0000);
        run_instr(16'hD525, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
